chunked_adder: RTL and testbench
================================

Name: chunked_adder

Overview:
- Parametrised, multi-cycle ripple adder/subtractor; next generation of the 4-bit combinational ripple-carry adder.
- Processes a WIDTH-bit operand pair CHUNK bits per clock, propagating carry between cycles.
- Adds carry-in, subtract mode, signed overflow and a start/busy/done handshake.
- Sits between switch/register inputs and the seven-segment/LED display path, where a narrow adder slice saves area.

Parameters:
WIDTH, 16, operand/result width in bits; must be an integer multiple of CHUNK.
CHUNK, 4, bits added per clock cycle; 1 <= CHUNK <= WIDTH.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request an operation; sampled only in IDLE or DONE.
A  input  WIDTH  operand A; captured on the accepted start edge.
B  input  WIDTH  operand B; captured on the accepted start edge.
Cin  input  1  carry-in for addition; ignored when Sub=1.
Sub  input  1  1 = A-B, 0 = A+B+Cin; captured with the operands.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse when S/Co/Ovf are updated.
S  output  WIDTH  result.
Co  output  1  carry out of the MSB; for subtract, 1 = no borrow.
Ovf  output  1  signed (two's-complement) overflow.

Behaviour:
- Reset: all of the following are forced to 0 on the first rising edge with reset=1, regardless of state:
  - state = IDLE
  - busy, done
  - S, Co, Ovf
  - internal operand registers, chunk index and carry.
- Reset mid-operation: the operation is abandoned and no done pulse is produced.
- NCH = WIDTH/CHUNK. The chunk index counter is sized to hold NCH-1.
- States:
  - IDLE: busy=0, done=0. start=1 latches A, B^{WIDTH{Sub}}, and carry = Sub ? 1 : Cin; index=0; go to RUN.
  - RUN: busy=1. Each cycle:
    - add chunk[index] of the latched A and B' plus the carry, using the CHUNK-bit ripple sub-module;
    - write the sum into the internal working register at bits [index*CHUNK +: CHUNK];
    - update the carry; index++.
    - When index = NCH-1: load S from the working register (including the current chunk), Co = final carry, Ovf = carry-into-MSB XOR carry-out-of-MSB; go to DONE.
  - DONE: done=1, busy=0 for exactly one cycle, then IDLE. start=1 in DONE is accepted exactly as in IDLE, so back-to-back operations lose no cycle.
- Latency: with start accepted at edge t, done is high in the cycle following edge t+NCH. Throughput is one operation per NCH+1 cycles.
- start while busy=1: ignored. Operand changes during RUN have no effect.
- Outputs S/Co/Ovf change only on the edge entering DONE. They hold their value through IDLE and the next RUN until the next completion.
- Arithmetic wraps modulo 2^WIDTH. Co and Ovf are computed from the full WIDTH-bit result.
- NCH=1 (CHUNK=WIDTH): RUN lasts one cycle and the block behaves as a registered adder.

Decomposition:
- Package adder_pkg:
  - state_t enum {IDLE, RUN, DONE};
  - localparam-style function nch(WIDTH, CHUNK);
  - elaboration-time assertion that WIDTH % CHUNK == 0.
- Sub-module chunk_ripple:
  - combinational CHUNK-bit ripple-carry adder built from full adders;
  - ports a, b, cin, s, cout, c_msb (carry into the top bit, used for Ovf);
  - one instance only.
- The FSM, index counter, carry register and output registers stay in chunked_adder.

Test Plan (WIDTH=16, CHUNK=4 unless noted):
1. reset held 2 cycles, then released, then start with A=FFFF B=0001 Cin=0 Sub=0 -> busy high 4 cycles; done on the 5th cycle after the start edge; S=0000 Co=1 Ovf=0; outputs remain 0 before done.
2. Overflow/carry-in checks:
   - A=7FFF B=0000 Cin=1 -> S=8000 Co=0 Ovf=1.
   - A=FFFF B=FFFF Cin=0 -> S=FFFE Co=1 Ovf=0.
3. Subtract checks:
   - Sub=1 A=0005 B=0003 Cin=1 -> S=0002 Co=1 Ovf=0 (Cin ignored).
   - Sub=1 A=0003 B=0005 -> S=FFFE Co=0 Ovf=0.
   - Sub=1 A=8000 B=0001 -> S=7FFF Ovf=1.
4. Handshake checks:
   - start with A=1111 B=2222; pulse start again mid-RUN with A=FFFF -> ignored; result S=3333.
   - start asserted in the DONE cycle with A=0001 B=0001 -> accepted; next done gives S=0002 after 5 cycles with no idle gap.
5. Reset mid-operation: reset asserted in the 2nd RUN cycle -> next cycle busy=0, S=0000, no done pulse; a subsequent start with A=000A B=0005 completes normally with S=000F.
6. Random sweep with a self-checking reference model:
   - configurations WIDTH=8 CHUNK=1 (8 RUN cycles), WIDTH=8 CHUNK=8 (1 RUN cycle), WIDTH=12 CHUNK=4;
   - 1000 operations with random A/B/Cin/Sub;
   - S/Co/Ovf must match the reference model and done latency must equal NCH+1.

Source files
------------

// File: rtl/chunked_adder_pkg.sv
// Shared types and configuration helpers for the chunked adder.
// Holds the FSM state encoding and the chunk-count arithmetic.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int nch(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic bit cfg_ok(input int width, input int chunk);
        return (chunk >= 1) && (chunk <= width) && (width % chunk == 0);
    endfunction

endpackage

// File: rtl/chunked_adder_if.sv
// Operand/result bundle and start/busy/done handshake of the chunked adder.
// master drives requests, slave is the adder itself.
interface chunked_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             Co;
    logic             Ovf;

    modport master (
        output start, A, B, Cin, Sub,
        input  busy, done, S, Co, Ovf
    );

    modport slave (
        input  start, A, B, Cin, Sub,
        output busy, done, S, Co, Ovf
    );
endinterface

// File: rtl/chunked_adder_ripple.sv
// Combinational N-bit ripple-carry slice built from full adders.
// c_msb is the carry into the top bit, needed for signed overflow.
module chunk_ripple #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         c_msb
);
    logic [N:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout  = c[N];
    assign c_msb = c[N-1];
endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock,
// carry kept in a register between slices.
module chunked_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic       clk,
    input  logic       reset,
    chunked_adder_if.slave bus
);
    localparam int NCH = nch(WIDTH, CHUNK);
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCH - 1);

    if (!cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
        $error("chunked_adder: WIDTH must be a multiple of CHUNK");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             c_q, c_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;

    logic [31:0]      off;
    logic [CHUNK-1:0] ca, cb, csum;
    logic             cout, cmsb;

    assign off = 32'(idx_q) * CHUNK;
    assign ca  = a_q[off +: CHUNK];
    assign cb  = b_q[off +: CHUNK];

    chunk_ripple #(.N(CHUNK)) u_ripple (
        .a     (ca),
        .b     (cb),
        .cin   (c_q),
        .s     (csum),
        .cout  (cout),
        .c_msb (cmsb)
    );

    // Next-state: accept in IDLE/DONE, one slice per RUN cycle.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        s_d     = s_q;
        idx_d   = idx_q;
        c_d     = c_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B ^ {WIDTH{bus.Sub}};
                    c_d     = bus.Sub | bus.Cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                work_d[off +: CHUNK] = csum;
                c_d   = cout;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    s_d     = work_d;
                    co_d    = cout;
                    ovf_d   = cmsb ^ cout;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            s_q     <= '0;
            idx_q   <= '0;
            c_q     <= 1'b0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            s_q     <= s_d;
            idx_q   <= idx_d;
            c_q     <= c_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.S    = s_q;
    assign bus.Co   = co_q;
    assign bus.Ovf  = ovf_q;
endmodule

// File: tb/tb_chunked_adder.sv
// Bench for chunked_adder: directed cases on a 16/4 instance plus a
// random sweep over 16/4, 8/1, 8/8 and 12/4 against an arithmetic model.
module tb_chunked_adder;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    chunked_adder_if #(.WIDTH(16)) m ();
    chunked_adder_if #(.WIDTH(8))  i81 ();
    chunked_adder_if #(.WIDTH(8))  i88 ();
    chunked_adder_if #(.WIDTH(12)) i124 ();

    chunked_adder #(.WIDTH(16), .CHUNK(4)) dut (.clk(clk), .reset(reset), .bus(m));
    chunked_adder #(.WIDTH(8),  .CHUNK(1)) d81 (.clk(clk), .reset(reset), .bus(i81));
    chunked_adder #(.WIDTH(8),  .CHUNK(8)) d88 (.clk(clk), .reset(reset), .bus(i88));
    chunked_adder #(.WIDTH(12), .CHUNK(4)) d124 (.clk(clk), .reset(reset), .bus(i124));

    // Reference: signed/unsigned integer arithmetic on the full operands.
    function automatic void model(input int w, input longint a, input longint b,
                                  input bit cin, input bit sub,
                                  output longint s, output bit co, output bit ov);
        longint msk, ua, ub, sa, sb, rs, ru, hi;
        msk = (longint'(1) << w) - 1;
        hi  = longint'(1) << (w - 1);
        ua  = a & msk;
        ub  = b & msk;
        sa  = (ua >= hi) ? ua - (longint'(1) << w) : ua;
        sb  = (ub >= hi) ? ub - (longint'(1) << w) : ub;
        rs  = sub ? sa - sb : sa + sb + longint'(cin);
        ru  = sub ? ua - ub : ua + ub + longint'(cin);
        s   = ru & msk;
        co  = sub ? (ua >= ub) : (ru > msk);
        ov  = (rs > hi - 1) || (rs < -hi);
    endfunction

    task automatic idle_all();
        m.start = 0; m.A = '0; m.B = '0; m.Cin = 0; m.Sub = 0;
        i81.start = 0; i81.A = '0; i81.B = '0; i81.Cin = 0; i81.Sub = 0;
        i88.start = 0; i88.A = '0; i88.B = '0; i88.Cin = 0; i88.Sub = 0;
        i124.start = 0; i124.A = '0; i124.B = '0; i124.Cin = 0; i124.Sub = 0;
    endtask

    // One operation on the 16/4 instance; returns at the done cycle.
    task automatic main_op(input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic sub,
                           output logic [15:0] s, output logic co,
                           output logic ov, output int lat);
        @(negedge clk);
        m.A = a; m.B = b; m.Cin = cin; m.Sub = sub; m.start = 1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        m.start = 0;
        while (!m.done && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!m.done) lat = -1;
        s = m.S; co = m.Co; ov = m.Ovf;
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({m.busy, m.done} !== 2'b00) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00", {m.busy, m.done});
        end
        checks++;
        if ({m.S, m.Co, m.Ovf} !== 18'h0) begin
            failures++;
            $display("FAIL reset_out got=%h exp=0", {m.S, m.Co, m.Ovf});
        end
        checks++;
        if ({i81.busy, i88.busy, i124.busy, i81.done, i88.done, i124.done} !== 6'b0) begin
            failures++;
            $display("FAIL reset_others got=%b exp=0",
                     {i81.busy, i88.busy, i124.busy, i81.done, i88.done, i124.done});
        end
        reset = 0;
    endtask

    task automatic test_basic();
        @(negedge clk);
        m.A = 16'hFFFF; m.B = 16'h0001; m.Cin = 0; m.Sub = 0; m.start = 1;
        @(posedge clk);
        @(negedge clk);
        m.start = 0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({m.busy, m.done, m.S, m.Co, m.Ovf} !== {2'b10, 18'h0}) begin
                failures++;
                $display("FAIL basic_run%0d got=%h exp=%h", k,
                         {m.busy, m.done, m.S, m.Co, m.Ovf}, {2'b10, 18'h0});
            end
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if ({m.busy, m.done} !== 2'b01) begin
            failures++;
            $display("FAIL basic_done got=%b exp=01", {m.busy, m.done});
        end
        checks++;
        if ({m.S, m.Co, m.Ovf} !== {16'h0000, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL basic_result got=%h exp=%h", {m.S, m.Co, m.Ovf},
                     {16'h0000, 1'b1, 1'b0});
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({m.busy, m.done} !== 2'b00) begin
            failures++;
            $display("FAIL basic_pulse got=%b exp=00", {m.busy, m.done});
        end
    endtask

    task automatic test_carry();
        logic [15:0] s; logic co, ov; int lat;
        main_op(16'h7FFF, 16'h0000, 1, 0, s, co, ov, lat);
        checks++;
        if ({s, co, ov} !== {16'h8000, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL cin_ovf got=%h exp=%h", {s, co, ov}, {16'h8000, 1'b0, 1'b1});
        end
        main_op(16'hFFFF, 16'hFFFF, 0, 0, s, co, ov, lat);
        checks++;
        if ({s, co, ov} !== {16'hFFFE, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL add_ffff got=%h exp=%h", {s, co, ov}, {16'hFFFE, 1'b1, 1'b0});
        end
    endtask

    task automatic test_sub();
        logic [15:0] s; logic co, ov; int lat;
        main_op(16'h0005, 16'h0003, 1, 1, s, co, ov, lat);
        checks++;
        if ({s, co, ov} !== {16'h0002, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL sub_5_3 got=%h exp=%h", {s, co, ov}, {16'h0002, 1'b1, 1'b0});
        end
        main_op(16'h0003, 16'h0005, 0, 1, s, co, ov, lat);
        checks++;
        if ({s, co, ov} !== {16'hFFFE, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL sub_3_5 got=%h exp=%h", {s, co, ov}, {16'hFFFE, 1'b0, 1'b0});
        end
        main_op(16'h8000, 16'h0001, 0, 1, s, co, ov, lat);
        checks++;
        if ({s, co, ov} !== {16'h7FFF, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL sub_ovf got=%h exp=%h", {s, co, ov}, {16'h7FFF, 1'b1, 1'b1});
        end
    endtask

    task automatic test_handshake();
        int n;
        int lat;
        @(negedge clk);
        m.A = 16'h1111; m.B = 16'h2222; m.Cin = 0; m.Sub = 0; m.start = 1;
        @(posedge clk);
        @(negedge clk);
        m.start = 0;
        @(posedge clk);
        @(negedge clk);
        m.A = 16'hFFFF; m.start = 1;
        @(posedge clk);
        @(negedge clk);
        m.start = 0; m.A = 16'h0000;
        n = 0;
        while (!m.done && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        checks++;
        if (!m.done || m.S !== 16'h3333) begin
            failures++;
            $display("FAIL ignore_start got=%h done=%b exp=3333", m.S, m.done);
        end
        m.A = 16'h0001; m.B = 16'h0001; m.start = 1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        m.start = 0;
        checks++;
        if (m.busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept got=%b exp=1", m.busy);
        end
        while (!m.done && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checks++;
        if (!m.done || lat != 5 || m.S !== 16'h0002) begin
            failures++;
            $display("FAIL b2b_result got=%h lat=%0d exp=0002 lat=5", m.S, lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] s; logic co, ov; int lat;
        bit seen;
        @(negedge clk);
        m.A = 16'h1234; m.B = 16'h1111; m.Cin = 0; m.Sub = 0; m.start = 1;
        @(posedge clk);
        @(negedge clk);
        m.start = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1;
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        checks++;
        if ({m.busy, m.done, m.S, m.Co, m.Ovf} !== 20'h0) begin
            failures++;
            $display("FAIL rst_mid got=%h exp=0", {m.busy, m.done, m.S, m.Co, m.Ovf});
        end
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
            if (m.done) seen = 1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL rst_nodone got=1 exp=0");
        end
        main_op(16'h000A, 16'h0005, 0, 0, s, co, ov, lat);
        checks++;
        if ({s, co, ov} !== {16'h000F, 1'b0, 1'b0} || lat != 5) begin
            failures++;
            $display("FAIL rst_after got=%h lat=%0d exp=%h lat=5", {s, co, ov}, lat,
                     {16'h000F, 1'b0, 1'b0});
        end
    endtask

    task automatic test_random();
        int     wd[4]  = '{16, 8, 8, 12};
        int     exl[4] = '{5, 9, 2, 4};
        int     lat[4];
        longint gs[4];
        bit     gc[4], gv[4];
        logic [31:0] a, b;
        bit cin, sub;
        longint es;
        bit ec, ev;
        for (int op = 0; op < 1000; op++) begin
            a = $urandom; b = $urandom;
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            @(negedge clk);
            m.A = a[15:0];    m.B = b[15:0];    m.Cin = cin;    m.Sub = sub;    m.start = 1;
            i81.A = a[7:0];   i81.B = b[7:0];   i81.Cin = cin;  i81.Sub = sub;  i81.start = 1;
            i88.A = a[7:0];   i88.B = b[7:0];   i88.Cin = cin;  i88.Sub = sub;  i88.start = 1;
            i124.A = a[11:0]; i124.B = b[11:0]; i124.Cin = cin; i124.Sub = sub; i124.start = 1;
            @(posedge clk);
            @(negedge clk);
            m.start = 0; i81.start = 0; i88.start = 0; i124.start = 0;
            for (int d = 0; d < 4; d++) lat[d] = -1;
            for (int cnt = 1; cnt <= 12; cnt++) begin
                if (m.done && lat[0] < 0) begin
                    lat[0] = cnt; gs[0] = longint'(m.S); gc[0] = m.Co; gv[0] = m.Ovf;
                end
                if (i81.done && lat[1] < 0) begin
                    lat[1] = cnt; gs[1] = longint'(i81.S); gc[1] = i81.Co; gv[1] = i81.Ovf;
                end
                if (i88.done && lat[2] < 0) begin
                    lat[2] = cnt; gs[2] = longint'(i88.S); gc[2] = i88.Co; gv[2] = i88.Ovf;
                end
                if (i124.done && lat[3] < 0) begin
                    lat[3] = cnt; gs[3] = longint'(i124.S); gc[3] = i124.Co; gv[3] = i124.Ovf;
                end
                if (cnt < 12) begin
                    @(posedge clk);
                    @(negedge clk);
                end
            end
            for (int d = 0; d < 4; d++) begin
                model(wd[d], longint'(a), longint'(b), cin, sub, es, ec, ev);
                checks++;
                if (lat[d] != exl[d]) begin
                    failures++;
                    $display("FAIL rand_lat cfg%0d op%0d got=%0d exp=%0d", d, op, lat[d], exl[d]);
                end
                checks++;
                if (lat[d] < 0 || gs[d] != es || gc[d] != ec || gv[d] != ev) begin
                    failures++;
                    $display("FAIL rand_res cfg%0d op%0d a=%h b=%h cin=%0d sub=%0d got=%h/%0d/%0d exp=%h/%0d/%0d",
                             d, op, a, b, cin, sub, gs[d], gc[d], gv[d], es, ec, ev);
                end
            end
        end
    endtask

    initial begin
        idle_all();
        test_reset();
        test_basic();
        test_carry();
        test_sub();
        test_handshake();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
